board_editor: RTL and testbench

//  Write side of the board memory that the frame renderer reads. Applies user edits (toggle/set/clear one

---
 rtl/board_editor_if.sv | 35 +++
 rtl/board_editor.sv | 224 ++++++++++++++++++++++
 tb/tb_board_editor.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_editor_if.sv
// board_editor_if
//   Edit-request handshake between the user-input logic and the board editor.
//   A request is accepted on the rising clock edge where req_valid_in and
//   req_ready_out are both high.
//
//   req_valid_in   requester -> editor  edit request valid
//   req_ready_out  editor -> requester  editor idle and able to accept
//   req_op_in      requester -> editor  00 toggle, 01 set, 10 clear cell, 11 clear board
//   cursor_x_in    requester -> editor  target cell x (board coordinates)
//   cursor_y_in    requester -> editor  target cell y (board coordinates)
interface board_editor_if #(
  parameter int LOG_BOARD_SIZE = 6
);
  logic                      req_valid_in;
  logic                      req_ready_out;
  logic [1:0]                req_op_in;
  logic [LOG_BOARD_SIZE-1:0] cursor_x_in;
  logic [LOG_BOARD_SIZE-1:0] cursor_y_in;

  modport master (
    output req_valid_in,
    output req_op_in,
    output cursor_x_in,
    output cursor_y_in,
    input  req_ready_out
  );

  modport slave (
    input  req_valid_in,
    input  req_op_in,
    input  cursor_x_in,
    input  cursor_y_in,
    output req_ready_out
  );
endinterface

// File: rtl/board_editor.sv
// board_editor
//   Write side of the board memory that the frame renderer reads. User edits
//   (toggle / set / clear one cell, or wipe the whole board) are applied by
//   read-modify-write on the board RAM port. The RAM is only touched while
//   render_done_in is high (renderer blank window), so a frame never shows a
//   half-applied edit.
//
//   Word/bit mapping matches the render fetch path:
//     addr = y * (BOARD_SIZE/WORD_SIZE) + (x >> LOG_WORD_SIZE)
//     bit  = WORD_SIZE-1 - x[LOG_WORD_SIZE-1:0]   (MSB = leftmost cell)
//
// Ports
//   clk_130mhz      system clock
//   rst_in          asynchronous, active-high reset
//   req             edit-request handshake (board_editor_if.slave)
//   render_done_in  renderer blank window; RAM access only while high
//   addr_out        board RAM word address
//   data_r_in       board RAM read data (READ_LATENCY cycles after addr_out)
//   data_w_out      board RAM write data
//   we_out          board RAM write enable
//   busy_out        high whenever the editor is not idle
//   done_out        one-cycle pulse the cycle after the final write of a request
module board_editor #(
  parameter int READ_LATENCY   = 2,
  parameter int WORD_SIZE      = 16,
  parameter int LOG_WORD_SIZE  = 4,
  parameter int BOARD_SIZE     = 64,
  parameter int LOG_BOARD_SIZE = 6,
  parameter int LOG_MAX_ADDR   = 8
) (
  input  logic                    clk_130mhz,
  input  logic                    rst_in,
  board_editor_if.slave           req,
  input  logic                    render_done_in,
  output logic [LOG_MAX_ADDR-1:0] addr_out,
  input  logic [WORD_SIZE-1:0]    data_r_in,
  output logic [WORD_SIZE-1:0]    data_w_out,
  output logic                    we_out,
  output logic                    busy_out,
  output logic                    done_out
);

  // Rows hold a power-of-two number of words, so y*WORDS_PER_ROW is a shift.
  localparam int LOG_WPR = LOG_BOARD_SIZE - LOG_WORD_SIZE;
  localparam int CNT_W   = 3;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);
  localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR =
    LOG_MAX_ADDR'((BOARD_SIZE * BOARD_SIZE) / WORD_SIZE - 1);

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_WIPE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLANK,
    S_READ,
    S_WRITE,
    S_SWEEP
  } state_t;

  // RAM word holding cell (x, y).
  function automatic logic [LOG_MAX_ADDR-1:0] word_addr(
    input logic [LOG_BOARD_SIZE-1:0] x,
    input logic [LOG_BOARD_SIZE-1:0] y
  );
    word_addr = (LOG_MAX_ADDR'(y) << LOG_WPR) | LOG_MAX_ADDR'(x >> LOG_WORD_SIZE);
  endfunction

  // One-hot mask of the cell inside its word; leftmost cell is the MSB.
  function automatic logic [WORD_SIZE-1:0] cell_mask(
    input logic [LOG_BOARD_SIZE-1:0] x
  );
    logic [WORD_SIZE-1:0] msb;
    msb = '0;
    msb[WORD_SIZE-1] = 1'b1;
    cell_mask = msb >> x[LOG_WORD_SIZE-1:0];
  endfunction

  function automatic logic [WORD_SIZE-1:0] apply_edit(
    input logic [1:0]           op,
    input logic [WORD_SIZE-1:0] word,
    input logic [WORD_SIZE-1:0] mask
  );
    case (op)
      OP_TOGGLE: apply_edit = word ^ mask;
      OP_SET:    apply_edit = word | mask;
      OP_CLEAR:  apply_edit = word & ~mask;
      default:   apply_edit = word;
    endcase
  endfunction

  state_t                    state_q, state_n;
  logic [1:0]                op_q, op_n;
  logic [LOG_BOARD_SIZE-1:0] x_q, x_n;
  logic [LOG_BOARD_SIZE-1:0] y_q, y_n;
  logic [WORD_SIZE-1:0]      word_q, word_n;
  logic [CNT_W-1:0]          cnt_q, cnt_n;
  logic [LOG_MAX_ADDR-1:0]   sweep_q, sweep_n;
  logic                      fin_q, fin_n;

  logic [LOG_MAX_ADDR-1:0]   addr_n;
  logic [WORD_SIZE-1:0]      data_w_n;
  logic                      we_n;

  // Next-state and next-output decode
  always_comb begin
    state_n  = state_q;
    op_n     = op_q;
    x_n      = x_q;
    y_n      = y_q;
    word_n   = word_q;
    cnt_n    = cnt_q;
    sweep_n  = sweep_q;
    fin_n    = 1'b0;
    addr_n   = addr_out;
    data_w_n = data_w_out;
    we_n     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req.req_valid_in && req.req_ready_out) begin
          op_n = req.req_op_in;
          x_n  = req.cursor_x_in;
          y_n  = req.cursor_y_in;
          if (req.req_op_in == OP_WIPE) begin
            sweep_n = '0;
            addr_n  = '0;
            state_n = S_SWEEP;
          end else begin
            state_n = S_WAIT_BLANK;
          end
        end
      end

      S_WAIT_BLANK: begin
        if (render_done_in) begin
          addr_n  = word_addr(x_q, y_q);
          cnt_n   = '0;
          state_n = S_READ;
        end
      end

      S_READ: begin
        // Losing the blank window mid-read discards the read entirely; the
        // word is fetched again once the next window opens.
        if (!render_done_in) begin
          state_n = S_WAIT_BLANK;
        end else if (cnt_q == LAT) begin
          word_n  = apply_edit(op_q, data_r_in, cell_mask(x_q));
          state_n = S_WRITE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      S_WRITE: begin
        // Without a blank window the captured word may already be stale, so
        // fall back to a full re-read rather than holding the write.
        if (render_done_in) begin
          we_n     = 1'b1;
          data_w_n = word_q;
          fin_n    = 1'b1;
          state_n  = S_IDLE;
        end else begin
          state_n = S_WAIT_BLANK;
        end
      end

      S_SWEEP: begin
        if (render_done_in) begin
          we_n     = 1'b1;
          data_w_n = '0;
          addr_n   = sweep_q;
          sweep_n  = sweep_q + LOG_MAX_ADDR'(1);
          if (sweep_q == LAST_ADDR) begin
            fin_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk_130mhz or posedge rst_in) begin
    if (rst_in) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      sweep_q           <= '0;
      fin_q             <= 1'b0;
      req.req_ready_out <= 1'b1;
      addr_out          <= '0;
      data_w_out        <= '0;
      we_out            <= 1'b0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
    end else begin
      state_q           <= state_n;
      cnt_q             <= cnt_n;
      sweep_q           <= sweep_n;
      fin_q             <= fin_n;
      req.req_ready_out <= (state_n == S_IDLE);
      addr_out          <= addr_n;
      data_w_out        <= data_w_n;
      we_out            <= we_n;
      busy_out          <= (state_n != S_IDLE);
      // fin_q rides alongside the final write, so done lands one cycle later.
      done_out          <= fin_q;
    end
  end

  // Request/data holding registers
  always_ff @(posedge clk_130mhz) begin
    op_q   <= op_n;
    x_q    <= x_n;
    y_q    <= y_n;
    word_q <= word_n;
  end

endmodule

// File: tb/tb_board_editor.sv
module tb_board_editor;
  localparam int WS     = 16;
  localparam int BS     = 64;
  localparam int LBS    = 6;
  localparam int LMA    = 8;
  localparam int WPR    = BS / WS;
  localparam int NWORDS = BS * BS / WS;

  logic           clk_130mhz = 1'b0;
  logic           rst_in;
  logic           render_done_in;
  logic [LMA-1:0] addr_out;
  logic [WS-1:0]  data_r_in;
  logic [WS-1:0]  data_w_out;
  logic           we_out;
  logic           busy_out;
  logic           done_out;

  always #4 clk_130mhz = ~clk_130mhz;

  board_editor_if #(.LOG_BOARD_SIZE(LBS)) req_if ();

  board_editor #(
    .READ_LATENCY(2), .WORD_SIZE(WS), .LOG_WORD_SIZE(4),
    .BOARD_SIZE(BS), .LOG_BOARD_SIZE(LBS), .LOG_MAX_ADDR(LMA)
  ) dut (
    .clk_130mhz     (clk_130mhz),
    .rst_in         (rst_in),
    .req            (req_if),
    .render_done_in (render_done_in),
    .addr_out       (addr_out),
    .data_r_in      (data_r_in),
    .data_w_out     (data_w_out),
    .we_out         (we_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  // Board RAM model: two-cycle read (array read + output register).
  logic [WS-1:0]  mem [NWORDS];
  logic [WS-1:0]  rd_p1;
  logic           tb_we;
  logic [LMA-1:0] tb_addr;
  logic [WS-1:0]  tb_data;
  logic [1:0]     tb_fill;

  always @(posedge clk_130mhz) begin
    if (tb_fill == 2'd1) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= tb_data;
    end else if (tb_fill == 2'd2) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= WS'($urandom);
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (we_out) begin
      mem[addr_out] <= data_w_out;
    end
    rd_p1     <= mem[addr_out];
    data_r_in <= rd_p1;
  end

  // Write / done monitor; also flags any write whose decision cycle lacked blank.
  int             wr_cnt = 0;
  int             done_cnt = 0;
  int             viol = 0;
  logic [LMA-1:0] last_waddr = '0;
  logic [WS-1:0]  last_wdata = '0;
  logic           rd_prev = 1'b0;

  always @(posedge clk_130mhz) begin
    if (we_out) begin
      wr_cnt++;
      last_waddr = addr_out;
      last_wdata = data_w_out;
      if (!rd_prev) viol++;
    end
    if (done_out) done_cnt++;
    rd_prev = render_done_in;
  end

  // render_done_in driver: 0 manual, 1 random (~75% high), 2 fixed 50 high / 50 low.
  int   rd_mode = 0;
  logic rd_manual = 1'b0;
  int   cyc = 0;

  initial begin
    render_done_in = 1'b0;
    forever begin
      @(negedge clk_130mhz);
      cyc++;
      if (rd_mode == 0)      render_done_in = rd_manual;
      else if (rd_mode == 1) render_done_in = ($urandom_range(0, 3) != 0);
      else                   render_done_in = ((cyc % 100) < 50);
    end
  end

  // Reference board: one bit per cell, indexed [y][x].
  logic refb [BS][BS];

  function automatic logic [WS-1:0] exp_word(input int y, input int col);
    logic [WS-1:0] w;
    for (int i = 0; i < WS; i++) w[WS-1-i] = refb[y][col*WS + i];
    return w;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_130mhz);
    #1;
  endtask

  task automatic tb_write(input int a, input logic [WS-1:0] d);
    tb_addr = LMA'(a);
    tb_data = d;
    tb_we   = 1'b1;
    tick();
    tb_we   = 1'b0;
  endtask

  task automatic tb_fill_mem(input logic [1:0] mode, input logic [WS-1:0] d);
    tb_data = d;
    tb_fill = mode;
    tick();
    tb_fill = 2'd0;
  endtask

  task automatic send_req(input logic [1:0] op, input int x, input int y);
    bit acc;
    acc = 1'b0;
    req_if.req_valid_in = 1'b1;
    req_if.req_op_in    = op;
    req_if.cursor_x_in  = LBS'(x);
    req_if.cursor_y_in  = LBS'(y);
    for (int k = 0; k < 5000; k++) begin
      if (req_if.req_ready_out) begin
        tick();
        acc = 1'b1;
        break;
      end
      tick();
    end
    req_if.req_valid_in = 1'b0;
    // Cursor must be ignored after acceptance.
    req_if.cursor_x_in  = LBS'($urandom);
    req_if.cursor_y_in  = LBS'($urandom);
    chk("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_130mhz);
      if (done_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    int s_wr, s_dn, cnt_a, cnt_b, x, y, op;
    bit hit;
    rst_in = 1'b1;
    req_if.req_valid_in = 1'b0;
    req_if.req_op_in    = 2'b00;
    req_if.cursor_x_in  = '0;
    req_if.cursor_y_in  = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0; tb_fill = 2'd0;
    repeat (3) tick();

    // Reset state
    chk("rst_we",     32'(we_out), 32'd0);
    chk("rst_addr",   32'(addr_out), 32'd0);
    chk("rst_data_w", 32'(data_w_out), 32'd0);
    chk("rst_busy",   32'(busy_out), 32'd0);
    chk("rst_done",   32'(done_out), 32'd0);
    tb_fill_mem(2'd1, 16'h0000);
    @(negedge clk_130mhz);
    rst_in = 1'b0;
    tick();
    chk("rel_ready", 32'(req_if.req_ready_out), 32'd1);

    // Toggle (5,2) on a zero word -> word 8 = 0x0400
    rd_manual = 1'b1;
    tick(); tick();
    s_wr = wr_cnt; s_dn = done_cnt;
    send_req(2'b00, 5, 2);
    chk("t1_busy", 32'(busy_out), 32'd1);
    wait_done(50, "t1_done");
    chk("t1_nwr",   32'(wr_cnt - s_wr), 32'd1);
    chk("t1_addr",  32'(last_waddr), 32'd8);
    chk("t1_data",  32'(last_wdata), 32'h0400);
    chk("t1_ndone", 32'(done_cnt - s_dn), 32'd1);
    chk("t1_mem",   32'(mem[8]), 32'h0400);

    // Set (17,3) with bit already set, then clear it
    tb_write(13, 16'h4000);
    send_req(2'b01, 17, 3);
    wait_done(50, "t2_set_done");
    chk("t2_set_addr", 32'(last_waddr), 32'd13);
    chk("t2_set_data", 32'(last_wdata), 32'h4000);
    send_req(2'b10, 17, 3);
    wait_done(50, "t2_clr_done");
    chk("t2_clr_data", 32'(last_wdata), 32'h0000);
    chk("t2_clr_mem",  32'(mem[13]), 32'h0000);

    // No blank for 100 cycles -> no write until it rises
    rd_manual = 1'b0;
    tick(); tick();
    s_wr = wr_cnt;
    send_req(2'b00, 0, 0);
    repeat (100) tick();
    chk("t3_nowr", 32'(wr_cnt - s_wr), 32'd0);
    chk("t3_busy", 32'(busy_out), 32'd1);
    rd_manual = 1'b1;
    wait_done(50, "t3_done");
    chk("t3_mem", 32'(mem[0]), 32'h8000);
    chk("t3_nwr", 32'(wr_cnt - s_wr), 32'd1);

    // Blank drops during READ, then during WRITE; word changes in between
    rd_manual = 1'b0;
    tick(); tick();
    s_wr = wr_cnt;
    send_req(2'b00, 20, 10);
    repeat (5) tick();
    rd_manual = 1'b1;
    tick(); tick();
    rd_manual = 1'b0;
    repeat (3) tick();
    chk("t4_read_drop_nowr", 32'(wr_cnt - s_wr), 32'd0);
    tb_write(41, 16'h00F0);
    rd_manual = 1'b1;
    tick(); tick(); tick(); tick();
    rd_manual = 1'b0;
    repeat (3) tick();
    chk("t4_write_drop_nowr", 32'(wr_cnt - s_wr), 32'd0);
    chk("t4_busy", 32'(busy_out), 32'd1);
    tb_write(41, 16'h00FF);
    rd_manual = 1'b1;
    wait_done(50, "t4_done");
    chk("t4_mem", 32'(mem[41]), 32'h08FF);
    chk("t4_nwr", 32'(wr_cnt - s_wr), 32'd1);

    // Clear board with 50/50 blank pattern
    tb_fill_mem(2'd2, 16'h0000);
    tb_write(7, 16'hA5A5);
    rd_mode = 2;
    s_wr = wr_cnt; s_dn = done_cnt;
    send_req(2'b11, $urandom_range(0, BS-1), $urandom_range(0, BS-1));
    wait_done(2000, "t5_done");
    cnt_a = 0;
    for (int a = 0; a < NWORDS; a++) if (mem[a] != '0) cnt_a++;
    chk("t5_nonzero", 32'(cnt_a), 32'd0);
    chk("t5_nwr", 32'(wr_cnt - s_wr), 32'(NWORDS));
    repeat (20) tick();
    chk("t5_ndone", 32'(done_cnt - s_dn), 32'd1);

    // Reset in the middle of a sweep at address 40
    rd_mode = 0;
    rd_manual = 1'b1;
    tb_fill_mem(2'd1, 16'hFFFF);
    send_req(2'b11, 0, 0);
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_130mhz);
      if (we_out && addr_out == LMA'(40)) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t6_reach40", 32'(hit), 32'd1);
    rst_in = 1'b1;
    #1;
    chk("t6_we",     32'(we_out), 32'd0);
    chk("t6_addr",   32'(addr_out), 32'd0);
    chk("t6_data_w", 32'(data_w_out), 32'd0);
    chk("t6_busy",   32'(busy_out), 32'd0);
    repeat (3) tick();
    cnt_a = 0; cnt_b = 0;
    for (int a = 0; a < 40; a++) if (mem[a] == '0) cnt_a++;
    for (int a = 40; a < NWORDS; a++) if (mem[a] == 16'hFFFF) cnt_b++;
    chk("t6_cleared_low",  32'(cnt_a), 32'd40);
    chk("t6_untouched_hi", 32'(cnt_b), 32'(NWORDS - 40));
    @(negedge clk_130mhz);
    rst_in = 1'b0;
    tick();
    chk("t6_ready", 32'(req_if.req_ready_out), 32'd1);
    chk("t6_busy_rel", 32'(busy_out), 32'd0);

    // Randomized edits against the cell-level reference board
    rd_mode = 1;
    send_req(2'b11, 0, 0);
    wait_done(4000, "rnd_wipe_done");
    for (int yy = 0; yy < BS; yy++)
      for (int xx = 0; xx < BS; xx++) refb[yy][xx] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      x  = $urandom_range(0, BS-1);
      y  = $urandom_range(0, BS-1);
      send_req(2'(op), x, y);
      wait_done(4000, "rnd_done");
      if (op == 3) begin
        for (int yy = 0; yy < BS; yy++)
          for (int xx = 0; xx < BS; xx++) refb[yy][xx] = 1'b0;
      end else begin
        if (op == 0)      refb[y][x] = ~refb[y][x];
        else if (op == 1) refb[y][x] = 1'b1;
        else              refb[y][x] = 1'b0;
        chk("rnd_word", 32'(mem[y*WPR + x/WS]), 32'(exp_word(y, x/WS)));
      end
    end
    cnt_a = 0;
    for (int a = 0; a < NWORDS; a++) if (mem[a] !== exp_word(a / WPR, a % WPR)) cnt_a++;
    chk("rnd_board_mismatches", 32'(cnt_a), 32'd0);
    chk("no_write_outside_blank", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
